// File: rtl/compact_instruction_packer.sv
// Re-encodes RV32I instructions as RVC parcels where an exact equivalent exists
// and packs the resulting 16/32-bit parcel stream little-endian into 32-bit words.
module compact_instruction_packer #(
    parameter int unsigned ENABLE_COMPRESSION = 1,
    parameter int unsigned COUNT_WIDTH        = 16
) (
    input  logic                   clock,
    input  logic                   resetN,
    input  logic [31:0]            inInstruction,
    input  logic                   inValid,
    output logic                   inReady,
    input  logic                   flush,
    output logic [31:0]            outWord,
    output logic                   outValid,
    input  logic                   outReady,
    output logic                   empty,
    output logic                   illegalInput,
    output logic [COUNT_WIDTH-1:0] compressedCount
);

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [11:0] s_imm;
    logic        rd_p;
    logic        rs1_p;
    logic        rs2_p;
    logic        is_c;
    logic [15:0] c16;
    logic        use_c;
    logic        illegal_in;

    assign opc   = inInstruction[6:0];
    assign f3    = inInstruction[14:12];
    assign f7    = inInstruction[31:25];
    assign rd    = inInstruction[11:7];
    assign rs1   = inInstruction[19:15];
    assign rs2   = inInstruction[24:20];
    assign s_imm = {inInstruction[31:25], inInstruction[11:7]};
    // Primed registers x8..x15 are the only ones the 3-bit RVC fields can name.
    assign rd_p  = (rd[4:3] == 2'b01);
    assign rs1_p = (rs1[4:3] == 2'b01);
    assign rs2_p = (rs2[4:3] == 2'b01);

    always_comb begin
        is_c = 1'b0;
        c16  = 16'h0000;
        if (opc == 7'b0000011 && f3 == 3'b010 && rd_p && rs1_p &&
            inInstruction[21:20] == 2'b00 && inInstruction[31:27] == 5'b00000) begin
            is_c = 1'b1;
            c16  = {3'b010, inInstruction[25:23], rs1[2:0], inInstruction[22],
                    inInstruction[26], rd[2:0], 2'b00};
        end else if (opc == 7'b0100011 && f3 == 3'b010 && rs1_p && rs2_p &&
                     s_imm[1:0] == 2'b00 && s_imm[11:7] == 5'b00000) begin
            is_c = 1'b1;
            c16  = {3'b110, s_imm[5:3], rs1[2:0], s_imm[2], s_imm[6], rs2[2:0], 2'b00};
        end else if (opc == 7'b0110011 && rd == rs1 && rd_p && rs2_p &&
                     ({f7, f3} == 10'b0100000_000 || {f7, f3} == 10'b0000000_100 ||
                      {f7, f3} == 10'b0000000_110 || {f7, f3} == 10'b0000000_111)) begin
            is_c = 1'b1;
            c16  = {3'b100, 1'b0, 2'b11, rd[2:0], (f3 == 3'b000) ? 2'b00 : f3[1:0] ^ 2'b01 ^ {1'b0, f3[1] ^ f3[0] ^ 1'b1} ^ 2'b01, rs2[2:0], 2'b01};
            case (f3)
                3'b000:  c16[6:5] = 2'b00;
                3'b100:  c16[6:5] = 2'b01;
                3'b110:  c16[6:5] = 2'b10;
                default: c16[6:5] = 2'b11;
            endcase
        end else if (opc == 7'b0010011 && f3 == 3'b111 && rd == rs1 && rd_p &&
                     inInstruction[31:25] == {7{inInstruction[25]}}) begin
            is_c = 1'b1;
            c16  = {3'b100, inInstruction[25], 2'b10, rd[2:0], inInstruction[24:20], 2'b01};
        end else if (opc == 7'b0110011 && f7 == 7'b0000000 && f3 == 3'b000 &&
                     rd == rs1 && rd != 5'd0 && rs2 != 5'd0) begin
            is_c = 1'b1;
            c16  = {3'b100, 1'b1, rd, rs2, 2'b10};
        end
    end

    assign use_c      = (ENABLE_COMPRESSION != 0) && is_c;
    assign illegal_in = (inInstruction[1:0] != 2'b11) || (inInstruction == 32'h0);

    logic                   pend_valid_q, pend_valid_d;
    logic [15:0]            pend_half_q, pend_half_d;
    logic                   out_valid_q, out_valid_d;
    logic [31:0]            out_word_q, out_word_d;
    logic                   illegal_q, illegal_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   can_load;
    logic                   in_fire;

    assign can_load = !out_valid_q || outReady;
    assign inReady  = can_load && !flush;
    assign in_fire  = inValid && inReady;

    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_half_d  = pend_half_q;
        out_valid_d  = out_valid_q;
        out_word_d   = out_word_q;
        illegal_d    = illegal_q;
        count_d      = count_q;
        if (out_valid_q && outReady) begin
            out_valid_d = 1'b0;
        end
        if (flush) begin
            // Pad the odd halfword with C.NOP so the word stays decodable.
            if (pend_valid_q && can_load) begin
                out_word_d   = {16'h0001, pend_half_q};
                out_valid_d  = 1'b1;
                pend_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            if (illegal_in) begin
                illegal_d = 1'b1;
            end else if (use_c) begin
                if (count_q != {COUNT_WIDTH{1'b1}}) begin
                    count_d = count_q + COUNT_WIDTH'(1);
                end
                if (pend_valid_q) begin
                    out_word_d   = {c16, pend_half_q};
                    out_valid_d  = 1'b1;
                    pend_valid_d = 1'b0;
                end else begin
                    pend_half_d  = c16;
                    pend_valid_d = 1'b1;
                end
            end else begin
                out_valid_d = 1'b1;
                if (pend_valid_q) begin
                    out_word_d  = {inInstruction[15:0], pend_half_q};
                    pend_half_d = inInstruction[31:16];
                end else begin
                    out_word_d = inInstruction;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            pend_valid_q <= 1'b0;
            pend_half_q  <= 16'h0000;
            out_valid_q  <= 1'b0;
            out_word_q   <= 32'h0;
            illegal_q    <= 1'b0;
            count_q      <= '0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_half_q  <= pend_half_d;
            out_valid_q  <= out_valid_d;
            out_word_q   <= out_word_d;
            illegal_q    <= illegal_d;
            count_q      <= count_d;
        end
    end

    assign outWord         = out_word_q;
    assign outValid        = out_valid_q;
    assign empty           = !pend_valid_q && !out_valid_q;
    assign illegalInput    = illegal_q;
    assign compressedCount = count_q;

endmodule

// File: tb/tb_compact_instruction_packer.sv
// Directed bench for compact_instruction_packer: packing, compression boundaries,
// flush padding, backpressure, illegal input and asynchronous reset.
module tb_compact_instruction_packer;

    logic        clock = 1'b0;
    logic        resetN;
    logic [31:0] inInstruction;
    logic        inValid;
    logic        flush;
    logic        outReady;

    logic        inReady, outValid, empty, illegalInput;
    logic [31:0] outWord;
    logic [15:0] compressedCount;

    logic        nc_inReady, nc_outValid, nc_empty, nc_illegal;
    logic [31:0] nc_outWord;
    logic [15:0] nc_count;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    compact_instruction_packer #(.ENABLE_COMPRESSION(1), .COUNT_WIDTH(16)) u_dut (
        .clock(clock), .resetN(resetN), .inInstruction(inInstruction), .inValid(inValid),
        .inReady(inReady), .flush(flush), .outWord(outWord), .outValid(outValid),
        .outReady(outReady), .empty(empty), .illegalInput(illegalInput),
        .compressedCount(compressedCount)
    );

    compact_instruction_packer #(.ENABLE_COMPRESSION(0), .COUNT_WIDTH(16)) u_nc (
        .clock(clock), .resetN(resetN), .inInstruction(inInstruction), .inValid(inValid),
        .inReady(nc_inReady), .flush(flush), .outWord(nc_outWord), .outValid(nc_outValid),
        .outReady(outReady), .empty(nc_empty), .illegalInput(nc_illegal),
        .compressedCount(nc_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        resetN        = 1'b0;
        inInstruction = 32'h0;
        inValid       = 1'b0;
        flush         = 1'b0;
        outReady      = 1'b1;
        #1;
        check("rst_outValid", 32'(outValid), 32'd0);
        check("rst_outWord", outWord, 32'h0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_illegal", 32'(illegalInput), 32'd0);
        check("rst_count", 32'(compressedCount), 32'd0);
        step();
        step();
        resetN = 1'b1;
        step();

        // add x10,x10,x11 then lw x9,4(x8): two C parcels share one word
        inInstruction = 32'h00B50533;
        inValid       = 1'b1;
        step();
        check("t1_no_out", 32'(outValid), 32'd0);
        check("t1_pending", 32'(empty), 32'd0);
        inInstruction = 32'h00442483;
        step();
        check("t1_valid", 32'(outValid), 32'd1);
        check("t1_word", outWord, 32'h4044952E);
        check("t1_count", 32'(compressedCount), 32'd2);
        inValid = 1'b0;
        step();
        check("t1_drained", 32'(outValid), 32'd0);
        check("t1_empty", 32'(empty), 32'd1);

        // addi x1,x0,5 passes through from an empty buffer
        inInstruction = 32'h00500093;
        inValid       = 1'b1;
        step();
        check("t2_word", outWord, 32'h00500093);
        check("t2_valid", 32'(outValid), 32'd1);
        check("t2_count", 32'(compressedCount), 32'd2);
        inValid = 1'b0;
        step();

        // halfword + 32-bit straddle, then flush pads with C.NOP
        inInstruction = 32'h00B50533;
        inValid       = 1'b1;
        step();
        inInstruction = 32'h00500093;
        step();
        check("t3_word0", outWord, 32'h0093952E);
        check("t3_pending", 32'(empty), 32'd0);
        check("t3_count", 32'(compressedCount), 32'd3);
        inValid = 1'b0;
        flush   = 1'b1;
        #1;
        check("t3_flush_ready", 32'(inReady), 32'd0);
        step();
        check("t3_word1", outWord, 32'h00010050);
        check("t3_valid1", 32'(outValid), 32'd1);
        flush = 1'b0;
        step();
        check("t3_empty", 32'(empty), 32'd1);

        // non-compressible boundaries: andi imm 64, lw offset 128
        inInstruction = 32'h04047413;
        inValid       = 1'b1;
        step();
        check("t4_andi64", outWord, 32'h04047413);
        inInstruction = 32'h08042483;
        step();
        check("t4_lw128", outWord, 32'h08042483);
        check("t4_count", 32'(compressedCount), 32'd3);
        check("t4_empty", 32'(empty), 32'd0);

        // sw x9,8(x10) + and x8,x8,x9; sub x8,x8,x9 + andi x8,x8,-1
        inInstruction = 32'h00952423;
        step();
        check("t5_nc_sw", nc_outWord, 32'h00952423);
        inInstruction = 32'h00947433;
        step();
        check("t5_sw_and", outWord, 32'h8C65C504);
        check("t5_nc_and", nc_outWord, 32'h00947433);
        check("t5_nc_count", 32'(nc_count), 32'd0);
        inInstruction = 32'h40940433;
        step();
        inInstruction = 32'hFFF47413;
        step();
        check("t5_sub_andi", outWord, 32'h987D8C05);
        check("t5_count", 32'(compressedCount), 32'd7);
        inValid = 1'b0;
        step();
        check("t5_empty", 32'(empty), 32'd1);

        // backpressure: first word held, no input taken until release
        outReady      = 1'b0;
        inInstruction = 32'h00500093;
        inValid       = 1'b1;
        step();
        check("t6_first", outWord, 32'h00500093);
        check("t6_stall_ready", 32'(inReady), 32'd0);
        inInstruction = 32'h08042483;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t6_hold_word", outWord, 32'h00500093);
            check("t6_hold_ready", 32'(inReady), 32'd0);
        end
        outReady = 1'b1;
        step();
        check("t6_second", outWord, 32'h08042483);
        check("t6_second_valid", 32'(outValid), 32'd1);
        inValid = 1'b0;
        step();
        check("t6_no_dup", 32'(outValid), 32'd0);

        // illegal input is flagged and dropped
        inInstruction = 32'h0000952E;
        inValid       = 1'b1;
        step();
        inValid = 1'b0;
        check("t7_illegal", 32'(illegalInput), 32'd1);
        check("t7_no_out", 32'(outValid), 32'd0);
        check("t7_empty", 32'(empty), 32'd1);
        check("t7_count", 32'(compressedCount), 32'd7);

        // async reset with a pending halfword discards it
        inInstruction = 32'h00B50533;
        inValid       = 1'b1;
        step();
        inValid = 1'b0;
        check("t8_pending", 32'(empty), 32'd0);
        resetN = 1'b0;
        #1;
        check("t8_outValid", 32'(outValid), 32'd0);
        check("t8_outWord", outWord, 32'h0);
        check("t8_illegal", 32'(illegalInput), 32'd0);
        check("t8_count", 32'(compressedCount), 32'd0);
        check("t8_empty", 32'(empty), 32'd1);
        step();
        resetN = 1'b1;
        inInstruction = 32'h00500093;
        inValid       = 1'b1;
        step();
        inValid = 1'b0;
        check("t8_after_word", outWord, 32'h00500093);
        check("t8_after_count", 32'(compressedCount), 32'd0);
        step();
        check("t8_after_empty", 32'(empty), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
